// File: rtl/transpose_fifo_sched.sv
// Transpose-FIFO sequencer: LOAD steers ROWS rows by one-hot wr_en; RUN drives a skewed en wavefront, then pulses done.
// Latency: en[0] rises 1 cycle after the final accept, done follows DEPTH+ROWS cycles after it; in_valid low stalls LOAD.
module transpose_fifo_sched #(
    parameter int DEPTH = 8,
    parameter int ROWS  = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [ROWS-1:0] wr_en,
    output logic [ROWS-1:0] en,
    output logic            busy,
    output logic            done
);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (DEPTH + ROWS > 1) ? $clog2(DEPTH + ROWS) : 1;
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
    localparam logic [CW-1:0] CYC_LAST = CW'(DEPTH + ROWS - 2);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [RW-1:0] row_cnt_q, row_cnt_d;
    logic [CW-1:0] cyc_q, cyc_d;
    logic          accept;

    // abort suppresses the handshake so no row is taken in the cycle it is dropped
    always_comb begin
        in_ready = (state_q == S_LOAD) && !abort;
        accept   = in_ready && in_valid;
        busy     = (state_q != S_IDLE);
        done     = (state_q == S_DONE);
        wr_en    = '0;
        if (accept) begin
            wr_en[row_cnt_q] = 1'b1;
        end
        en = '0;
        for (int i = 0; i < ROWS; i++) begin
            en[i] = (state_q == S_RUN) && (int'(cyc_q) >= i) && (int'(cyc_q) < i + DEPTH);
        end
    end

    always_comb begin
        state_d   = state_q;
        row_cnt_d = row_cnt_q;
        cyc_d     = cyc_q;
        if (abort) begin
            state_d   = S_IDLE;
            row_cnt_d = '0;
            cyc_d     = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (accept) begin
                        row_cnt_d = row_cnt_q + 1'b1;
                        if (row_cnt_q == ROW_LAST) begin
                            state_d   = S_RUN;
                            row_cnt_d = '0;
                        end
                    end
                end
                S_RUN: begin
                    cyc_d = cyc_q + 1'b1;
                    if (cyc_q == CYC_LAST) begin
                        state_d = S_DONE;
                        cyc_d   = '0;
                    end
                end
                S_DONE: begin
                    state_d   = S_IDLE;
                    row_cnt_d = '0;
                    cyc_d     = '0;
                end
                default: begin
                    state_d   = S_IDLE;
                    row_cnt_d = '0;
                    cyc_d     = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            row_cnt_q <= '0;
            cyc_q     <= '0;
        end else begin
            state_q   <= state_d;
            row_cnt_q <= row_cnt_d;
            cyc_q     <= cyc_d;
        end
    end
endmodule

// File: tb/tb_transpose_fifo_sched.sv
// Bench for transpose_fifo_sched: an 8x8 and a DEPTH=4/ROWS=2 instance, each tracked by a
// timestamp model (rows counted, cycle of final accept) plus directed literal checks.
`timescale 1ns/1ps
module tb_transpose_fifo_sched;
    localparam int DA = 8, RA = 8, DB = 4, RB = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n   = 1'b0;
    logic [1:0] start_v = '0;
    logic [1:0] valid_v = '0;
    logic [1:0] abort_v = '0;

    logic       rdy_a, busy_a, done_a;
    logic [7:0] wr_a, en_a;
    logic       rdy_b, busy_b, done_b;
    logic [1:0] wr_b, en_b;

    int compared   = 0;
    int mismatched = 0;

    transpose_fifo_sched #(.DEPTH(DA), .ROWS(RA)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .abort(abort_v[0]),
        .in_valid(valid_v[0]), .in_ready(rdy_a), .wr_en(wr_a), .en(en_a),
        .busy(busy_a), .done(done_a)
    );

    transpose_fifo_sched #(.DEPTH(DB), .ROWS(RB)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .abort(abort_v[1]),
        .in_valid(valid_v[1]), .in_ready(rdy_b), .wr_en(wr_b), .en(en_b),
        .busy(busy_b), .done(done_b)
    );

    // Model: loading flag, rows taken so far, and the cycle index of the final accept.
    int m_dep [2] = '{DA, DB};
    int m_row [2] = '{RA, RB};
    bit m_load[2] = '{1'b0, 1'b0};
    int m_rows[2] = '{0, 0};
    int m_fin [2] = '{-1, -1};
    int cnt = 0;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                for (int k = 0; k < 2; k++) begin
                    m_load[k] = 1'b0;
                    m_rows[k] = 0;
                    m_fin[k]  = -1;
                end
            end else begin
                for (int k = 0; k < 2; k++) begin
                    if (abort_v[k]) begin
                        m_load[k] = 1'b0;
                        m_rows[k] = 0;
                        m_fin[k]  = -1;
                    end else if (m_fin[k] >= 0) begin
                        if (cnt - m_fin[k] == m_dep[k] + m_row[k]) m_fin[k] = -1;
                    end else if (m_load[k]) begin
                        if (valid_v[k]) begin
                            m_rows[k]++;
                            if (m_rows[k] == m_row[k]) begin
                                m_load[k] = 1'b0;
                                m_rows[k] = 0;
                                m_fin[k]  = cnt;
                            end
                        end
                    end else if (start_v[k]) begin
                        m_load[k] = 1'b1;
                        m_rows[k] = 0;
                    end
                end
                cnt++;
            end
        end
    end

    // Per-cycle comparison of both instances against the model.
    initial begin
        logic [18:0] act, exp_v;
        logic [7:0]  e_wr, e_en;
        logic        e_rdy, e_busy, e_done;
        int          kk;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                e_rdy  = rst_n && m_load[k] && !abort_v[k];
                e_wr   = '0;
                if (e_rdy && valid_v[k]) e_wr[m_rows[k]] = 1'b1;
                e_en   = '0;
                e_done = 1'b0;
                e_busy = rst_n && (m_load[k] || m_fin[k] >= 0);
                if (rst_n && m_fin[k] >= 0) begin
                    kk = cnt - m_fin[k];
                    for (int i = 0; i < m_row[k]; i++)
                        if (kk - 1 - i >= 0 && kk - 1 - i < m_dep[k]) e_en[i] = 1'b1;
                    e_done = (kk == m_dep[k] + m_row[k]);
                end
                exp_v = {e_rdy, e_wr, e_en, e_busy, e_done};
                if (k == 0) act = {rdy_a, wr_a, en_a, busy_a, done_a};
                else        act = {rdy_b, 6'b0, wr_b, 6'b0, en_b, busy_b, done_b};
                compared++;
                if (act !== exp_v) begin
                    mismatched++;
                    $display("FAIL model_dut%0d cycle %0d: got rdy=%b wr=%h en=%h busy=%b done=%b, expected rdy=%b wr=%h en=%h busy=%b done=%b",
                             k, cnt, act[18], act[17:10], act[9:2], act[1], act[0],
                             e_rdy, e_wr, e_en, e_busy, e_done);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: summary not reached");
        $fatal(1);
    end

    logic [7:0] exp_en_a [15] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF,
                                  8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80};
    logic [1:0] exp_en_b [5]  = '{2'h1, 2'h3, 2'h3, 2'h3, 2'h2};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        compared++;
        if (act !== exp_v) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // start, then ROWS back-to-back rows; returns in the first RUN cycle
    task automatic load_a(input bit hold_start);
        start_v[0] = 1'b1;
        step();
        start_v[0] = hold_start;
        #1 chk("load_rdy_a", 32'(rdy_a), 32'd1);
        for (int r = 0; r < RA; r++) begin
            valid_v[0] = 1'b1;
            #1 chk($sformatf("load_wr_a_row%0d", r), 32'(wr_a), 32'(1 << r));
            step();
        end
        valid_v[0] = 1'b0;
    endtask

    task automatic wait_done_a(input int budget, output int n);
        n = 1;
        while (n < budget) begin
            #1;
            if (done_a) return;
            step();
            n++;
        end
    endtask

    initial begin
        int n;
        int hi0, hi1;
        repeat (3) step();
        chk("rst_busy_a", 32'(busy_a), 32'd0);
        chk("rst_en_a", 32'(en_a), 32'd0);
        chk("rst_rdy_b", 32'(rdy_b), 32'd0);
        rst_n = 1'b1;
        step();

        // full 8x8 sequence
        load_a(1'b0);
        for (int c = 0; c < 15; c++) begin
            #1 chk($sformatf("run_en_a_c%0d", c), 32'(en_a), 32'(exp_en_a[c]));
            step();
        end
        #1 chk("done_a", 32'(done_a), 32'd1);
        chk("done_en_a", 32'(en_a), 32'd0);
        chk("done_busy_a", 32'(busy_a), 32'd1);
        step();
        #1 chk("idle_busy_a", 32'(busy_a), 32'd0);
        chk("idle_done_a", 32'(done_a), 32'd0);

        // stall after 4 rows, start held high through LOAD/RUN/DONE
        start_v[0] = 1'b1;
        step();
        for (int r = 0; r < 4; r++) begin
            valid_v[0] = 1'b1;
            #1 chk($sformatf("stall_pre_wr_row%0d", r), 32'(wr_a), 32'(1 << r));
            step();
        end
        valid_v[0] = 1'b0;
        for (int s = 0; s < 3; s++) begin
            #1 chk("stall_wr_a", 32'(wr_a), 32'd0);
            chk("stall_rdy_a", 32'(rdy_a), 32'd1);
            step();
        end
        valid_v[0] = 1'b1;
        #1 chk("resume_wr_a", 32'(wr_a), 32'h10);
        step();
        for (int r = 5; r < RA; r++) begin
            #1 chk($sformatf("resume_wr_row%0d", r), 32'(wr_a), 32'(1 << r));
            step();
        end
        valid_v[0] = 1'b0;
        wait_done_a(40, n);
        chk("start_held_run_len", 32'(n), 32'd16);
        start_v[0] = 1'b0;
        step();
        #1 chk("start_held_idle", 32'(busy_a), 32'd0);

        // async reset at RUN cyc=3
        load_a(1'b0);
        repeat (3) step();
        #1 chk("rst_mid_en_pre", 32'(en_a), 32'h0F);
        rst_n = 1'b0;
        #1 chk("rst_mid_en", 32'(en_a), 32'd0);
        chk("rst_mid_busy", 32'(busy_a), 32'd0);
        chk("rst_mid_done", 32'(done_a), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        #1 chk("rst_rel_busy", 32'(busy_a), 32'd0);
        chk("rst_rel_rdy", 32'(rdy_a), 32'd0);

        // abort at RUN cyc=5
        load_a(1'b0);
        repeat (5) step();
        #1 chk("abort_en_pre", 32'(en_a), 32'h3F);
        abort_v[0] = 1'b1;
        step();
        abort_v[0] = 1'b0;
        #1 chk("abort_en", 32'(en_a), 32'd0);
        chk("abort_busy", 32'(busy_a), 32'd0);
        n = 0;
        for (int c = 0; c < 20; c++) begin
            if (done_a) n++;
            step();
        end
        chk("abort_no_done", 32'(n), 32'd0);
        load_a(1'b0);
        wait_done_a(40, n);
        chk("after_abort_run_len", 32'(n), 32'd16);
        step();

        // DEPTH=4, ROWS=2 instance
        start_v[1] = 1'b1;
        step();
        start_v[1] = 1'b0;
        #1 chk("b_rdy", 32'(rdy_b), 32'd1);
        for (int r = 0; r < RB; r++) begin
            valid_v[1] = 1'b1;
            #1 chk($sformatf("b_wr_row%0d", r), 32'(wr_b), 32'(1 << r));
            step();
        end
        valid_v[1] = 1'b0;
        hi0 = 0;
        hi1 = 0;
        for (int c = 0; c < 5; c++) begin
            #1 chk($sformatf("b_en_c%0d", c), 32'(en_b), 32'(exp_en_b[c]));
            hi0 += int'(en_b[0]);
            hi1 += int'(en_b[1]);
            step();
        end
        #1 chk("b_done", 32'(done_b), 32'd1);
        chk("b_done_en", 32'(en_b), 32'd0);
        chk("b_en0_cycles", 32'(hi0), 32'd4);
        chk("b_en1_cycles", 32'(hi1), 32'd4);
        step();
        #1 chk("b_idle", 32'(busy_b), 32'd0);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
